// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: display-data staging and pin bundle.
// master = register/datapath side, slave = scan driver.
interface sevenseg_scan_if #(
  parameter int NDIG     = 4,
  parameter int BRIGHT_W = 3
);
  logic                  ld;
  logic [4*NDIG-1:0]     din;
  logic [NDIG-1:0]       dp;
  logic [NDIG-1:0]       en;
  logic [NDIG-1:0]       blink;
  logic [BRIGHT_W-1:0]   bright;
  logic                  upd_pend;
  logic                  frame;
  logic [7:0]            SSEG_CA;
  logic [NDIG-1:0]       SSEG_AN;

  modport master (
    output ld, din, dp, en, blink, bright,
    input  upd_pend, frame, SSEG_CA, SSEG_AN
  );

  modport slave (
    input  ld, din, dp, en, blink, bright,
    output upd_pend, frame, SSEG_CA, SSEG_AN
  );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed common-anode 7-seg driver, staged updates.
// Define SSEG_BLANK_LZ_EN to enable leading-zero blanking.
module sevenseg_scan #(
  parameter int NDIG         = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic           clk,
  input  logic           reset,
  sevenseg_scan_if.slave bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW  = (BLINK_FRAMES > 1) ?
                       $clog2(BLINK_FRAMES) : 1;
  localparam int TW  = BRIGHT_W + PW + 2;

  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NDIG - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] DIVW = TW'(DIV);

  typedef struct packed {
    logic [4*NDIG-1:0]   din;
    logic [NDIG-1:0]     dp;
    logic [NDIG-1:0]     en;
    logic [NDIG-1:0]     blink;
    logic [BRIGHT_W-1:0] bright;
  } disp_t;

  function automatic logic [6:0] seg(
    input logic [3:0] v
  );
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PW-1:0]   pcnt;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   fcnt;
  logic            bph;
  logic            upd;
  logic            frame_q;
  logic [NDIG-1:0] an_q;
  logic [7:0]      ca_q;
  disp_t           pend;
  disp_t           act;
  disp_t           stage_in;

  logic            tick;
  logic            wrap;
  logic [TW-1:0]   thr;
  logic [NDIG-1:0] lzb;
  logic [3:0]      nib;
  logic            cur_dp;
  logic            cur_en;
  logic            cur_blk;
  logic            cur_lzb;
  logic [NDIG-1:0] an_sel;
  logic            lit;

  assign tick = (pcnt == PMAX);
  assign wrap = tick && (idx == IMAX);

  assign stage_in = {bus.din, bus.dp, bus.en,
                     bus.blink, bus.bright};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= wrap ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt <= '0;
      bph  <= 1'b0;
    end else if (wrap) begin
      if (fcnt == FMAX) begin
        fcnt <= '0;
        bph  <= ~bph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // active only moves at a slot boundary; a same-cycle ld waits a slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      act  <= '0;
      upd  <= 1'b0;
    end else begin
      if (tick && upd) begin
        act <= pend;
      end
      if (bus.ld) begin
        pend <= stage_in;
        upd  <= 1'b1;
      end else if (tick) begin
        upd  <= 1'b0;
      end
    end
  end

  always_comb begin
    thr = TW'((TW'(act.bright) + TW'(1)) * DIVW);
    thr = thr >> BRIGHT_W;
  end

`ifdef SSEG_BLANK_LZ_EN
  always_comb begin
    lzb = '0;
    for (int i = 1; i < NDIG; i++) begin
      lzb[i] = ((act.din >> (4 * i)) == '0);
    end
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    nib     = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_blk = 1'b0;
    cur_lzb = 1'b0;
    an_sel  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        nib       = act.din[4*i +: 4];
        cur_dp    = act.dp[i];
        cur_en    = act.en[i];
        cur_blk   = act.blink[i];
        cur_lzb   = lzb[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  assign lit = cur_en
             & (TW'(pcnt) < thr)
             & ~(bph & cur_blk)
             & ~cur_lzb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q    <= '1;
      ca_q    <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (lit) begin
        an_q <= ~an_sel;
        ca_q <= {~cur_dp, seg(nib)};
      end else begin
        an_q <= '1;
        ca_q <= 8'hFF;
      end
    end
  end

  assign bus.SSEG_AN  = an_q;
  assign bus.SSEG_CA  = ca_q;
  assign bus.frame    = frame_q;
  assign bus.upd_pend = upd;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed + random stimulus against a
// cycle-count based reference of the scan display.
module tb_sevenseg_scan;

  localparam int NDIG = 4;
  localparam int BW   = 2;
  localparam int DIV  = 16;
  localparam int BF   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_if #(.NDIG(NDIG), .BRIGHT_W(BW)) bus ();

  sevenseg_scan #(
    .NDIG(NDIG), .CLK_HZ(1600), .SCAN_HZ(100),
    .BRIGHT_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // reference: position in scan derived from edges since reset
  int unsigned n;
  logic [15:0] a_din, p_din;
  logic [3:0]  a_dp, p_dp, a_en, p_en, a_bl, p_bl;
  logic [1:0]  a_br, p_br;
  bit          pf;
  logic [3:0]  m_an;
  logic [7:0]  m_ca;
  bit          m_fr;
  int          pc, slot, dg, bph, thr;
  logic [3:0]  nib;
  bit          lz, lit;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; pf = 0;
      a_din = 0; a_dp = 0; a_en = 0; a_bl = 0; a_br = 0;
      p_din = 0; p_dp = 0; p_en = 0; p_bl = 0; p_br = 0;
      m_an = 4'hF; m_ca = 8'hFF; m_fr = 0;
    end else begin
      pc   = n % DIV;
      slot = n / DIV;
      dg   = slot % NDIG;
      bph  = ((slot / NDIG) / BF) % 2;
      thr  = ((int'(a_br) + 1) * DIV) / (1 << BW);
      nib  = 4'(a_din >> (4 * dg));
`ifdef SSEG_BLANK_LZ_EN
      lz   = (dg > 0) && ((a_din >> (4 * dg)) == 0);
`else
      lz   = 0;
`endif
      lit  = a_en[dg] && (pc < thr) &&
             !(bph == 1 && a_bl[dg]) && !lz;
      m_an = lit ? (4'hF ^ (4'b1 << dg)) : 4'hF;
      m_ca = lit ? {~a_dp[dg], SEG[nib]} : 8'hFF;
      m_fr = (pc == DIV - 1) && (dg == NDIG - 1);
      if (pc == DIV - 1 && pf) begin
        a_din = p_din; a_dp = p_dp; a_en = p_en;
        a_bl = p_bl; a_br = p_br; pf = 0;
      end
      if (bus.ld) begin
        p_din = bus.din; p_dp = bus.dp; p_en = bus.en;
        p_bl = bus.blink; p_br = bus.bright; pf = 1;
      end
      n++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) begin
      @(negedge clk);
      chk("an", bus.SSEG_AN, m_an);
      chk("ca", bus.SSEG_CA, m_ca);
      chk("frame", bus.frame, m_fr);
      chk("upd_pend", bus.upd_pend, pf);
      chk("onehot", $countones(~bus.SSEG_AN) <= 1, 1);
    end
  endtask

  task automatic load(logic [15:0] d, logic [3:0] p,
                      logic [3:0] e, logic [3:0] b,
                      logic [1:0] r);
    bus.din = d; bus.dp = p; bus.en = e;
    bus.blink = b; bus.bright = r;
    bus.ld = 1'b1;
    cyc(1);
    bus.ld = 1'b0;
  endtask

  task automatic wait_pc(int k);
    int t = 0;
    while ((n % DIV) != k && t < 40) begin
      cyc(1);
      t++;
    end
    chk("wait_pc", (n % DIV) == k, 1);
  endtask

  task automatic wait_an(string tag, logic [3:0] code);
    int t = 0;
    while (bus.SSEG_AN !== code && t < 80) begin
      cyc(1);
      t++;
    end
    chk(tag, bus.SSEG_AN, code);
  endtask

  task automatic count_an(string tag, logic [3:0] code,
                          int len, int exp);
    int c = 0;
    for (int i = 0; i < len; i++) begin
      cyc(1);
      if (bus.SSEG_AN === code) c++;
    end
    chk(tag, c, exp);
  endtask

  initial begin
    bus.ld = 0; bus.din = 0; bus.dp = 0;
    bus.en = 0; bus.blink = 0; bus.bright = 0;
    repeat (3) @(negedge clk);
    chk("rst_an", bus.SSEG_AN, 4'hF);
    chk("rst_ca", bus.SSEG_CA, 8'hFF);
    chk("rst_frame", bus.frame, 0);
    chk("rst_upd", bus.upd_pend, 0);
    reset = 1'b1;
    cyc(20);

    // full brightness, hex pattern
    load(16'h12AF, 4'b0100, 4'hF, 4'h0, 2'd3);
    chk("pend_set", bus.upd_pend, 1);
    cyc(30);
    count_an("full_d0", 4'hE, 64, 16);
    count_an("full_d1", 4'hD, 64, 16);
    count_an("full_d2", 4'hB, 64, 16);
    count_an("full_d3", 4'h7, 64, 16);
    wait_an("seek_d0", 4'hE);
    chk("d0_ca", bus.SSEG_CA, 8'h8E);
    wait_an("seek_d2", 4'hB);
    chk("d2_dp", bus.SSEG_CA[7], 0);

    // dimming
    load(16'h12AF, 4'b0100, 4'hF, 4'h0, 2'd1);
    cyc(30);
    count_an("half_d1", 4'hD, 64, 8);
    load(16'h12AF, 4'b0100, 4'hF, 4'h0, 2'd0);
    cyc(30);
    count_an("qtr_d3", 4'h7, 64, 4);

    // overwrite while pending
    load(16'h3333, 4'h0, 4'hF, 4'h0, 2'd3);
    cyc(20);
    wait_pc(5);
    load(16'h4567, 4'h1, 4'hF, 4'h0, 2'd3);
    wait_pc(9);
    load(16'h89CD, 4'h2, 4'hF, 4'h0, 2'd3);
    chk("pend_ow", bus.upd_pend, 1);
    cyc(40);

    // ld coincident with a tick
    wait_pc(15);
    load(16'hBEEF, 4'h8, 4'hF, 4'h0, 2'd3);
    cyc(40);

    // blink digit 0
    load(16'h12AF, 4'h0, 4'hF, 4'h1, 2'd3);
    cyc(30);
    count_an("blink_d0", 4'hE, 256, 32);
    count_an("blink_d1", 4'hD, 256, 64);

    // leading zeros
    load(16'h0005, 4'h0, 4'hF, 4'h0, 2'd3);
    cyc(30);
    count_an("lz5_d0", 4'hE, 64, 16);
`ifdef SSEG_BLANK_LZ_EN
    count_an("lz5_d1", 4'hD, 64, 0);
`else
    count_an("lz5_d1", 4'hD, 64, 16);
`endif
    wait_an("seek_5", 4'hE);
    chk("d0_five", bus.SSEG_CA, 8'h92);
    load(16'h0000, 4'h0, 4'hF, 4'h0, 2'd3);
    cyc(30);
    wait_an("seek_0", 4'hE);
    chk("d0_zero", bus.SSEG_CA, 8'hC0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        wait_pc($urandom_range(0, 15));
      load(16'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 2'($urandom));
      cyc($urandom_range(1, 60));
    end
    load(16'h7E57, 4'hF, 4'hF, 4'h0, 2'd3);
    cyc(40);

    // async reset mid-scan
    wait_an("seek_pre", 4'hB);
    #2 reset = 1'b0;
    #1;
    chk("arst_an", bus.SSEG_AN, 4'hF);
    chk("arst_ca", bus.SSEG_CA, 8'hFF);
    chk("arst_frame", bus.frame, 0);
    chk("arst_upd", bus.upd_pend, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc(80);
    count_an("dark_d0", 4'hE, 64, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
